grey_to_binary_decoder: RTL and testbench
=========================================

GREY_TO_BINARY_DECODER -- requirements
Module: grey_to_binary_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the word width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: grey_in holds a word to decode.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-006 SHALL have port grey_in, input, WIDTH bits: Grey-coded input word.
REQ-007 SHALL have port out_valid, output, 1 bit: binary_out holds a completed result.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream consumes the result this cycle.
REQ-009 SHALL have port binary_out, output, WIDTH bits: decoded binary word, registered.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, HOLD.
REQ-012 SHALL assert in_ready only in IDLE and out_valid only in HOLD, both decoded from state (no combinational path from inputs).
REQ-013 SHALL accept a word on any edge where state is IDLE and in_valid=1, capturing grey_in into an internal register.
REQ-014 On that accepting edge it SHALL load binary_out[WIDTH-1] with grey_in[WIDTH-1], clear the other binary_out bits, and load the bit index with WIDTH-2.
REQ-015 On the accepting edge it SHALL go to SHIFT if WIDTH>1, otherwise directly to HOLD.
REQ-016 In SHIFT it SHALL resolve one bit per edge, MSB-first, as binary_out[idx] = binary_out[idx+1] XOR grey_reg[idx], then decrement idx.
REQ-017 It SHALL leave SHIFT for HOLD on the edge that resolves idx=0; idx SHALL never wrap below 0.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH-1 edges after the accepting edge (3 for WIDTH=4, 0 for WIDTH=1).
REQ-019 In HOLD, binary_out SHALL be stable, and it SHALL go to IDLE on the edge where out_ready=1.
REQ-020 With out_ready=0 it SHALL remain in HOLD indefinitely with binary_out unchanged.
REQ-021 in_valid and grey_in SHALL be ignored in SHIFT and HOLD; grey_in changes after acceptance SHALL NOT affect the result.
REQ-022 Sustained throughput with in_valid=out_ready=1 SHALL be one word per WIDTH+1 clock edges.
REQ-023 binary_out content outside HOLD SHALL be treated as don't-care by consumers, but SHALL be deterministic per REQ-014/REQ-016.
REQ-024 The result SHALL equal the bitwise prefix-XOR of the Grey word (inverse of binary-to-Grey: g[i] = b[i+1] XOR b[i], g[MSB] = b[MSB]).

Reset
REQ-025 When rst=1 at an edge, state SHALL become IDLE, and binary_out, grey_reg and idx SHALL become 0, regardless of current state.
REQ-026 After reset: in_ready=1, out_valid=0, busy=0, binary_out=0.
REQ-027 Reset asserted in SHIFT or HOLD SHALL discard the in-flight word with no output handshake.
REQ-028 rst SHALL take priority over all simultaneous in_valid/out_ready activity.

Structure
REQ-029 Shared package grey_pkg SHALL hold the FSM state enum (IDLE, SHIFT, HOLD) and the default-width constant GREY_WIDTH_DEFAULT = 4.
REQ-030 The block SHALL have no sub-module: one sequential process for state/data, one combinational process for next-state/outputs.
REQ-031 idx SHALL be sized $clog2(WIDTH) bits (minimum 1).

Verification
REQ-032 Reset, then grey_in=4'b0110 with in_valid=1 -> accepted edge 0, out_valid rises after edge 3, binary_out=4'b0100.
REQ-033 grey_in=4'b1000 -> binary_out=4'b1111; hold out_ready=0 for 5 cycles -> out_valid stays 1 and binary_out stays 4'b1111; out_ready=1 -> IDLE next edge.
REQ-034 Exhaustive 0..15: encode b with the team's binary-to-Grey block, feed it to this block -> binary_out==b for all 16 values.
REQ-035 Assert rst=1 for one cycle while in SHIFT (idx=1) -> next cycle: state IDLE, binary_out=0, out_valid=0, and no stray handshake occurs.
REQ-036 in_valid=out_ready=1 continuously with words 4'b0001, 4'b0011, 4'b0010 -> outputs 1, 2, 3, with accepting edges spaced 5 edges apart.
REQ-037 Instantiate with WIDTH=1: grey_in=1 -> out_valid on the edge after acceptance with binary_out=1.

Source files
------------

// File: rtl/grey_pkg.sv
// grey_pkg: shared definitions for the Grey-to-binary decoder.
//   grey_state_e        - decoder FSM state encoding (IDLE, SHIFT, HOLD)
//   GREY_WIDTH_DEFAULT  - default word width in bits
package grey_pkg;

    parameter int unsigned GREY_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } grey_state_e;

endpackage

// File: rtl/grey_to_binary_decoder.sv
// grey_to_binary_decoder: bit-serial Grey-to-binary converter with a valid/ready
// handshake on each side. A word is captured in IDLE, resolved one bit per clock
// MSB-first in SHIFT, and presented in HOLD until the consumer takes it.
//
// Ports
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   in_valid   - grey_in holds a word to decode
//   in_ready   - high in IDLE: a word is accepted this cycle if in_valid
//   grey_in    - Grey-coded input word
//   out_valid  - high in HOLD: binary_out holds a completed result
//   out_ready  - consumer takes the result this cycle
//   binary_out - decoded binary word (registered)
//   busy       - high whenever the FSM is not IDLE
module grey_to_binary_decoder
    import grey_pkg::*;
#(
    parameter int unsigned WIDTH = GREY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] grey_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] binary_out,
    output logic             busy
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // First bit resolved in SHIFT; the MSB is already known at acceptance.
    localparam logic [IDX_W-1:0] IDX_START = (WIDTH > 1) ? IDX_W'(WIDTH - 2) : '0;

    grey_state_e      state_q, state_d;
    logic [WIDTH-1:0] grey_q, grey_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    // Zero-extended copy so bin_ext[i+1] is in range for every bit position.
    logic [WIDTH:0]   bin_ext;

    assign bin_ext    = {1'b0, bin_q};
    assign binary_out = bin_q;

    always_comb begin
        state_d   = state_q;
        grey_d    = grey_q;
        bin_d     = bin_q;
        idx_d     = idx_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    grey_d             = grey_in;
                    bin_d              = '0;
                    bin_d[WIDTH-1]     = grey_in[WIDTH-1];
                    idx_d              = IDX_START;
                    state_d            = (WIDTH > 1) ? SHIFT : HOLD;
                end
            end
            SHIFT: begin
                // Prefix-XOR step: each bit is the bit above it XOR its Grey bit.
                for (int i = 0; i < WIDTH; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        bin_d[i] = bin_ext[i+1] ^ grey_q[i];
                    end
                end
                if (idx_q == '0) begin
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grey_q  <= '0;
            bin_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            grey_q  <= grey_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_grey_to_binary_decoder.sv
// Self-checking bench for grey_to_binary_decoder (WIDTH=4 and WIDTH=1 instances).
// Expected words go into a scoreboard queue when a word is accepted and are popped
// when the decoder presents a result.
module tb_grey_to_binary_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0] grey_in, binary_out;

    logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_busy;
    logic [0:0] w1_grey_in, w1_binary_out;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] sb_q[$];
    logic [0:0] sb1_q[$];

    always #5 clk = ~clk;

    grey_to_binary_decoder #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .grey_in(grey_in), .out_valid(out_valid), .out_ready(out_ready),
        .binary_out(binary_out), .busy(busy)
    );

    grey_to_binary_decoder #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .grey_in(w1_grey_in), .out_valid(w1_out_valid), .out_ready(w1_out_ready),
        .binary_out(w1_binary_out), .busy(w1_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid rises, bounded at 20.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; grey_in = 4'hA;
        w1_in_valid = 1'b0; w1_out_ready = 1'b0; w1_grey_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (binary_out !== 4'b0000) begin failures++; $display("FAIL reset_binary_out got=%b want=0000", binary_out); end
        checks++; if (w1_in_ready !== 1'b1 || w1_busy !== 1'b0) begin failures++; $display("FAIL reset_w1 got ready=%b busy=%b want 1/0", w1_in_ready, w1_busy); end
    endtask

    task automatic test_basic();
        int n;
        logic [3:0] exp;
        grey_in = 4'b0110; in_valid = 1'b1; sb_q.push_back(4'b0100);
        tick();
        in_valid = 1'b0; grey_in = 4'b1001;  // post-acceptance changes must not matter
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_after_accept got busy=%b out_valid=%b want 1/0", busy, out_valid); end
        wait_valid(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL basic_latency got=%0d want=3", n); end
        exp = sb_q.pop_front();
        checks++; if (binary_out !== exp) begin failures++; $display("FAIL basic_result got=%b want=%b", binary_out, exp); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_hold_stall();
        int n;
        logic [3:0] exp;
        grey_in = 4'b1000; in_valid = 1'b1; sb_q.push_back(4'b1111);
        tick();
        in_valid = 1'b0; grey_in = 4'b0000;
        wait_valid(n);
        checks++; if (n >= 20) begin failures++; $display("FAIL stall_timeout got=%0d edges want<20", n); end
        exp = sb_q.pop_front();
        checks++; if (binary_out !== exp) begin failures++; $display("FAIL stall_result got=%b want=%b", binary_out, exp); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;  // ignored while holding
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cycle=%0d got=%b want=1", c, out_valid); end
            checks++; if (binary_out !== 4'b1111) begin failures++; $display("FAIL stall_stable cycle=%0d got=%b want=1111", c, binary_out); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_exhaustive();
        int n;
        logic [3:0] b, exp;
        for (int v = 0; v < 16; v++) begin
            b = 4'(v);
            grey_in = b ^ (b >> 1); in_valid = 1'b1; sb_q.push_back(b);
            tick();
            in_valid = 1'b0; grey_in = ~grey_in;
            wait_valid(n);
            exp = sb_q.pop_front();
            checks++;
            if (!out_valid) begin
                failures++; $display("FAIL exhaustive_timeout value=%0d got out_valid=0 want=1", v);
            end else if (binary_out !== exp) begin
                failures++; $display("FAIL exhaustive value=%0d got=%b want=%b", v, binary_out, exp);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int hs;
        grey_in = 4'b1111; in_valid = 1'b1;
        tick();   // accept, idx=2
        in_valid = 1'b0;
        tick();   // idx=1
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL midreset_pre got busy=%b out_valid=%b want 1/0", busy, out_valid); end
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midreset_state got in_ready=%b busy=%b want 1/0", in_ready, busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
        checks++; if (binary_out !== 4'b0000) begin failures++; $display("FAIL midreset_binary_out got=%b want=0000", binary_out); end
        hs = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid && out_ready) hs++;
            tick();
        end
        out_ready = 1'b0;
        checks++; if (hs !== 0) begin failures++; $display("FAIL midreset_stray_handshake got=%0d want=0", hs); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] words[3];
        logic [3:0] expv[3];
        int         acc_edge[3];
        int         k, got;
        logic       a, h;
        logic [3:0] exp;
        words = '{4'b0001, 4'b0011, 4'b0010};
        expv  = '{4'd1, 4'd2, 4'd3};
        acc_edge = '{0, 0, 0};
        k = 0; got = 0;
        grey_in = words[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            a = in_ready && in_valid;
            h = out_valid && out_ready;
            if (a) sb_q.push_back(expv[k]);
            if (h) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected got=%b want=none", binary_out);
                end else begin
                    exp = sb_q.pop_front();
                    if (binary_out !== exp) begin failures++; $display("FAIL b2b_result got=%b want=%b", binary_out, exp); end
                end
                got++;
            end
            tick();
            if (a) begin
                acc_edge[k] = cyc;
                k++;
                if (k < 3) grey_in = words[k];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (got !== 3) begin failures++; $display("FAIL b2b_count got=%0d want=3", got); end
        checks++; if (acc_edge[1] - acc_edge[0] !== 5) begin failures++; $display("FAIL b2b_spacing01 got=%0d want=5", acc_edge[1] - acc_edge[0]); end
        checks++; if (acc_edge[2] - acc_edge[1] !== 5) begin failures++; $display("FAIL b2b_spacing12 got=%0d want=5", acc_edge[2] - acc_edge[1]); end
        sb_q.delete();
    endtask

    task automatic test_width1();
        logic [0:0] exp;
        for (int v = 1; v >= 0; v--) begin
            w1_grey_in = 1'(v); w1_in_valid = 1'b1; sb1_q.push_back(1'(v));
            tick();
            w1_in_valid = 1'b0; w1_grey_in = ~w1_grey_in;
            exp = sb1_q.pop_front();
            checks++; if (w1_out_valid !== 1'b1) begin failures++; $display("FAIL w1_latency value=%0d got out_valid=%b want=1", v, w1_out_valid); end
            checks++; if (w1_binary_out !== exp) begin failures++; $display("FAIL w1_result value=%0d got=%b want=%b", v, w1_binary_out, exp); end
            w1_out_ready = 1'b1;
            tick();
            w1_out_ready = 1'b0;
            checks++; if (w1_in_ready !== 1'b1) begin failures++; $display("FAIL w1_release got=%b want=1", w1_in_ready); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_exhaustive();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
